// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_sequencer_pkg
// Shared definitions for the multi-cycle shift/rotate sequencer:
//   - op encodings (OP_ROL, OP_SLL, OP_ROR, OP_SRL)
//   - FSM state encodings (ST_IDLE, ST_SHIFT, ST_DONE)
//   - fixed datapath width of the shift row
// -----------------------------------------------------------------------------
package shift_sequencer_pkg;

    localparam int SHIFT_W = 16;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift1_row.sv
// -----------------------------------------------------------------------------
// shift1_row
// Combinational 16-bit single-position shift/rotate row.
// Ports:
//   d   in  16  operand
//   s   in  1   1 = shift by one position, 0 = pass through
//   op  in  2   OP_ROL / OP_SLL / OP_ROR / OP_SRL
//   q   out 16  result
// Rotates wrap bit 15 <-> bit 0; logical shifts fill with zero.
// -----------------------------------------------------------------------------
module shift1_row
    import shift_sequencer_pkg::*;
(
    input  logic [SHIFT_W-1:0] d,
    input  logic               s,
    input  logic [1:0]         op,
    output logic [SHIFT_W-1:0] q
);

    logic [SHIFT_W-1:0] shifted;

    always_comb begin
        shifted = d;
        case (op)
            OP_ROL:  shifted = {d[SHIFT_W-2:0], d[SHIFT_W-1]};
            OP_SLL:  shifted = {d[SHIFT_W-2:0], 1'b0};
            OP_ROR:  shifted = {d[0], d[SHIFT_W-1:1]};
            OP_SRL:  shifted = {1'b0, d[SHIFT_W-1:1]};
            default: shifted = d;
        endcase
    end

    assign q = s ? shifted : d;

endmodule

// File: rtl/shift4_step.sv
// -----------------------------------------------------------------------------
// shift4_step
// Four chained shift1_row instances: advances the operand by four positions
// in one combinational step. Only built when SHIFT_NIBBLE_EN is defined.
// Ports:
//   d   in  16  operand
//   op  in  2   OP_ROL / OP_SLL / OP_ROR / OP_SRL
//   q   out 16  operand shifted/rotated by 4
// -----------------------------------------------------------------------------
`ifdef SHIFT_NIBBLE_EN
module shift4_step
    import shift_sequencer_pkg::*;
(
    input  logic [SHIFT_W-1:0] d,
    input  logic [1:0]         op,
    output logic [SHIFT_W-1:0] q
);

    logic [SHIFT_W-1:0] chain [0:4];

    assign chain[0] = d;

    for (genvar i = 0; i < 4; i++) begin : g_row
        shift1_row u_row (
            .d  (chain[i]),
            .s  (1'b1),
            .op (op),
            .q  (chain[i+1])
        );
    end

    assign q = chain[4];

endmodule
`endif

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle shift/rotate unit for the 16-bit datapath. Captures operand,
// count and op on an accepted start, then iterates a 1-bit shift row once per
// clock until the count is exhausted. Trades latency for area versus a full
// barrel shifter.
//
// Configuration macro: SHIFT_NIBBLE_EN
//   defined   : while 4 or more positions remain, advance 4 per clock
//   undefined : 1 position per clock
//   Results are identical in both builds; only latency differs.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous active-high reset
//   start     in   1   request, sampled only in IDLE
//   in_data   in   16  operand, captured on accepted start
//   cnt       in   4   shift amount 0..15
//   op        in   2   00 ROL, 01 SLL, 10 ROR, 11 SRL
//   busy      out  1   high whenever not IDLE
//   done      out  1   one-cycle pulse, out_data final in this cycle
//   out_data  out  16  result register, held until the next accepted start
// -----------------------------------------------------------------------------
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_data
);

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] rem_q;
    logic [1:0]       op_q;

    logic [WIDTH-1:0] row1_data;
    logic [WIDTH-1:0] step_data;
    logic [CNT_W-1:0] step_amt;

    shift1_row u_row1 (
        .d  (data_q),
        .s  (1'b1),
        .op (op_q),
        .q  (row1_data)
    );

`ifdef SHIFT_NIBBLE_EN
    logic [WIDTH-1:0] row4_data;
    logic             nibble;

    shift4_step u_step4 (
        .d  (data_q),
        .op (op_q),
        .q  (row4_data)
    );

    // Take a 4-position step only while at least 4 positions remain, so
    // the count can never underflow.
    assign nibble    = (rem_q >= CNT_W'(4));
    assign step_data = nibble ? row4_data : row1_data;
    assign step_amt  = nibble ? CNT_W'(4) : CNT_W'(1);
`else
    assign step_data = row1_data;
    assign step_amt  = CNT_W'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            data_q <= '0;
            rem_q  <= '0;
            op_q   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        data_q <= in_data;
                        op_q   <= op;
                        rem_q  <= cnt;
                        busy   <= 1'b1;
                        // A zero count skips SHIFT entirely.
                        if (cnt != '0) begin
                            state <= ST_SHIFT;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q <= step_data;
                    rem_q  <= rem_q - step_amt;
                    // This step consumes the last remaining positions.
                    if (rem_q == step_amt) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_data;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [15:0] out_data;

    int n_assert = 0;
    int n_fail   = 0;

    shift_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .cnt      (cnt),
        .op       (op),
        .busy     (busy),
        .done     (done),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result: plain arithmetic on a 32-bit widened operand.
    function automatic logic [15:0] ref_result(input logic [1:0] o, input logic [15:0] d, input int n);
        logic [31:0] x;
        logic [31:0] r;
        x = {16'h0000, d};
        case (o)
            2'b00:   r = (x << n) | (x >> (16 - n));
            2'b01:   r = x << n;
            2'b10:   r = (x >> n) | (x << (16 - n));
            default: r = x >> n;
        endcase
        return r[15:0];
    endfunction

    // Edges from the start edge up to the edge after which done is high.
    function automatic int ref_latency(input int n);
`ifdef SHIFT_NIBBLE_EN
        return n / 4 + n % 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request and follows it to completion. When inject is set a
    // stray start carrying 0xFFFF is pulsed while the unit is busy.
    task automatic run_op(input logic [1:0] o, input logic [15:0] d, input logic [3:0] c,
                          input bit inject, input string tag);
        int edges;
        int busy_cycles;
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        in_data = d;
        cnt     = c;
        @(posedge clk);
        #1;
        start   = 1'b0;
        // Scramble the inputs mid-operation; the captured request must win.
        in_data = 16'($urandom);
        cnt     = 4'($urandom);
        op      = 2'($urandom);
        edges       = 1;
        busy_cycles = 0;
        chk(busy, 1'b1, {tag, "_busy_after_start"});
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            if (inject && edges == 1) begin
                start   = 1'b1;
                in_data = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        if (busy) busy_cycles++;
        chk(edges, ref_latency(int'(c)), {tag, "_latency"});
        chk(out_data, ref_result(o, d, int'(c)), {tag, "_result"});
        chk(busy_cycles, ref_latency(int'(c)), {tag, "_busy_cycles"});
        @(posedge clk);
        #1;
        chk({busy, done}, 2'b00, {tag, "_idle_after_done"});
        chk(out_data, ref_result(o, d, int'(c)), {tag, "_hold"});
        if (inject) begin
            @(posedge clk);
            #1;
            chk(done, 1'b0, {tag, "_single_done"});
        end
    endtask

    initial begin
        int done_seen;
        logic [1:0]  r_op;
        logic [15:0] r_d;
        logic [3:0]  r_c;

        rst     = 1'b1;
        start   = 1'b0;
        in_data = '0;
        cnt     = '0;
        op      = '0;
        #12;
        chk({busy, done}, 2'b00, "reset_ctrl");
        chk(out_data, 16'h0000, "reset_data");
        @(negedge clk);
        rst = 1'b0;

        // Reset during SHIFT aborts at once and never yields a done.
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b01;
        in_data = 16'h00FF;
        cnt     = 4'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk({busy, done}, 2'b00, "midreset_ctrl");
        chk(out_data, 16'h0000, "midreset_data");
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        chk(done_seen, 0, "midreset_no_done");
        chk(out_data, 16'h0000, "midreset_idle_data");

        // Directed cases.
        run_op(2'b01, 16'h0001, 4'd4,  1'b0, "sll_4");
        run_op(2'b00, 16'h8001, 4'd1,  1'b0, "rol_1");
        run_op(2'b11, 16'h8000, 4'd15, 1'b0, "srl_15");
        run_op(2'b10, 16'h0001, 4'd0,  1'b0, "ror_0");
        run_op(2'b10, 16'h0001, 4'd3,  1'b1, "ror_3_inject");
        run_op(2'b00, 16'h1234, 4'd9,  1'b0, "rol_9");
        run_op(2'b01, 16'hFFFF, 4'd15, 1'b0, "sll_15");
        run_op(2'b00, 16'hA5C3, 4'd8,  1'b0, "rol_8");

        // Randomized requests against the reference model.
        for (int k = 0; k < 24; k++) begin
            r_op = 2'($urandom);
            r_d  = 16'($urandom);
            r_c  = 4'($urandom_range(0, 15));
            run_op(r_op, r_d, r_c, k[2], "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
